// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the register hazard scoreboard: the register address
// bus width, the default register-file size and the hard-wired zero register.
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue-stage bundle for the hazard scoreboard. The pipeline (master)
// presents read ports and issuing writes; the scoreboard (slave) answers with
// the bubble request, the blocking register and its bookkeeping outputs.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int LAT_W    = 3,
    parameter int STAT_W   = 16
) ();

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic [LAT_W-1:0]         iss_lat;
    logic                     bbl;
    logic [ADDR_W-1:0]        tar_addr;
    logic [NUM_REGS-1:0]      pending;
    logic [STAT_W-1:0]        stall_cnt;

    modport master (
        output rd_en, rd_addr, iss_valid, iss_addr, iss_lat,
        input  bbl, tar_addr, pending, stall_cnt
    );

    modport slave (
        input  rd_en, rd_addr, iss_valid, iss_addr, iss_lat,
        output bbl, tar_addr, pending, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register latency countdown. A load sets the remaining latency; otherwise
// a nonzero count steps down by one each cycle and zero holds. The nonzero
// flag marks the register as still pending.
module sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic             nonzero_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Next count: a load wins over the decrement, zero stays at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {LAT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(LAT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {LAT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != {LAT_W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard / bubble controller. Each architectural register has a
// countdown of cycles until its in-flight result becomes forwardable. Decode
// read ports are checked against the pre-edge state; any hit raises bbl in the
// same cycle and tar_addr names the register seen by the lowest hitting port.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int LAT_W    = 3,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave sb
);

    localparam int ADDR_SPACE = 1 << ADDR_W;

    logic [NUM_REGS-1:0]   pending_s;
    logic [ADDR_SPACE-1:0] pend_full_s;
    logic [ADDR_W-1:0]     rd_addr_s [NUM_RD];
    logic [NUM_RD-1:0]     hit_s;
    logic                  bbl_s;
    logic [ADDR_W-1:0]     tar_addr_s;
    logic                  accept_s;
    logic [STAT_W-1:0]     stall_cnt_q;
    logic [STAT_W-1:0]     stall_cnt_d;

    // Pending map widened to the full address space; addresses beyond the
    // register file read as never pending, so they can never hit.
    always_comb begin
        pend_full_s = {ADDR_SPACE{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_full_s[r] = pending_s[r];
        end
    end

    // Split the packed read-address bus into one address per port.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_s[i] = sb.rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Per-port hit: active port, not the zero register, register still pending.
    always_comb begin
        hit_s = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            hit_s[i] = sb.rd_en[i]
                     && (rd_addr_s[i] != ADDR_W'(ZERO_REG))
                     && pend_full_s[rd_addr_s[i]];
        end
    end

    assign bbl_s = |hit_s;

    // Report the register of the lowest-index hitting port (scan high to low
    // so the lowest index is written last).
    always_comb begin
        tar_addr_s = {ADDR_W{1'b0}};
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                tar_addr_s = rd_addr_s[i];
            end else begin
                tar_addr_s = tar_addr_s;
            end
        end
    end

    // A stalled issue stage re-presents later, so issues during a bubble are
    // dropped; zero latency and the zero register carry no hazard.
    assign accept_s = sb.iss_valid
                   && !bbl_s
                   && (sb.iss_addr != ADDR_W'(ZERO_REG))
                   && (sb.iss_lat != {LAT_W{1'b0}});

    assign pending_s[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        sb_counter #(
            .LAT_W (LAT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .load_i     (accept_s && (sb.iss_addr == ADDR_W'(r))),
            .load_val_i (sb.iss_lat),
            .nonzero_o  (pending_s[r])
        );
    end

    // Saturating count of bubble cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bbl_s && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall statistic register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {STAT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.bbl       = bbl_s;
    assign sb.tar_addr  = tar_addr_s;
    assign sb.pending   = pending_s;
    assign sb.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. The reference model keeps, per register, the
// absolute cycle at which its result becomes forwardable; a register is
// pending while the current cycle is earlier than that. A small register file
// (24 entries) exercises out-of-range addresses and a narrow statistic
// counter exercises saturation.
module tb_hazard_scoreboard;

    localparam int NR   = 24;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int LW   = 3;
    localparam int SW   = 5;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_scoreboard_if #(
        .NUM_REGS (NR), .ADDR_W (AW), .NUM_RD (NRD), .LAT_W (LW), .STAT_W (SW)
    ) sbif ();

    hazard_scoreboard #(
        .NUM_REGS (NR), .ADDR_W (AW), .NUM_RD (NRD), .LAT_W (LW), .STAT_W (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    int ready_at [NR];
    int cyc;
    int stall_m;
    int n_assert = 0;
    int n_fail   = 0;

    function automatic bit m_pend(int r);
        return (r > 0) && (r < NR) && (ready_at[r] > cyc);
    endfunction

    function automatic int port_addr(int i);
        return int'(sbif.rd_addr[i*AW +: AW]);
    endfunction

    function automatic bit m_hit(int i);
        return sbif.rd_en[i] && m_pend(port_addr(i));
    endfunction

    function automatic bit m_bbl();
        bit b = 1'b0;
        for (int i = 0; i < NRD; i++) b = b | m_hit(i);
        return b;
    endfunction

    function automatic int m_tar();
        for (int i = 0; i < NRD; i++) if (m_hit(i)) return port_addr(i);
        return 0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [NR-1:0] ep;
        for (int r = 0; r < NR; r++) ep[r] = m_pend(r);
        chk({tag, "_bbl"},   64'(sbif.bbl),       64'(m_bbl()));
        chk({tag, "_tar"},   64'(sbif.tar_addr),  64'(m_tar()));
        chk({tag, "_pend"},  64'(sbif.pending),   64'(ep));
        chk({tag, "_stall"}, 64'(sbif.stall_cnt), 64'(stall_m));
    endtask

    task automatic clear_inputs();
        sbif.rd_en     = '0;
        sbif.rd_addr   = '0;
        sbif.iss_valid = 1'b0;
        sbif.iss_addr  = '0;
        sbif.iss_lat   = '0;
    endtask

    task automatic set_rd(int i, int en, int a);
        logic [AW-1:0] av;
        av = AW'(a);
        sbif.rd_en[i] = en[0];
        sbif.rd_addr[i*AW +: AW] = av;
    endtask

    task automatic set_iss(int v, int a, int lat);
        sbif.iss_valid = v[0];
        sbif.iss_addr  = AW'(a);
        sbif.iss_lat   = LW'(lat);
    endtask

    // Advance one clock: settle the model from pre-edge inputs, then return
    // one time unit after the edge, where new inputs are driven.
    task automatic tick();
        bit b;
        bit acc;
        int ia;
        int il;
        b  = m_bbl();
        ia = int'(sbif.iss_addr);
        il = int'(sbif.iss_lat);
        acc = sbif.iss_valid && !b && (ia != 0) && (il != 0) && (ia < NR);
        if (b && (stall_m < SMAX)) stall_m++;
        @(posedge clk);
        cyc++;
        if (acc) ready_at[ia] = cyc + il;
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        stall_m = 0;
    endtask

    task automatic settle_check(string tag);
        #1;
        check_all(tag);
    endtask

    task automatic drain();
        clear_inputs();
        for (int k = 0; k < 8; k++) tick();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0;
        model_reset();
        clear_inputs();

        // 1. Reset held with random inputs.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sbif.rd_en     = NRD'($urandom);
            sbif.rd_addr   = (NRD*AW)'($urandom);
            sbif.iss_valid = 1'b1;
            sbif.iss_addr  = AW'($urandom_range(1, NR - 1));
            sbif.iss_lat   = LW'($urandom_range(1, 7));
            #1;
            chk("rst_bbl",   64'(sbif.bbl),       64'(0));
            chk("rst_tar",   64'(sbif.tar_addr),  64'(0));
            chk("rst_pend",  64'(sbif.pending),   64'(0));
            chk("rst_stall", 64'(sbif.stall_cnt), 64'(0));
            @(posedge clk);
            #1;
        end
        clear_inputs();
        rst = 1'b0;

        // 2. Issue r5 lat 3; read r5 once the count is down to 2.
        set_iss(1, 5, 3);
        settle_check("t2_iss");
        tick();
        clear_inputs();
        settle_check("t2_gap");
        chk("t2_pend5", 64'(sbif.pending[5]), 64'(1));
        tick();
        set_rd(0, 1, 5);
        settle_check("t2_s1");
        chk("t2_bbl1", 64'(sbif.bbl), 64'(1));
        chk("t2_tar1", 64'(sbif.tar_addr), 64'(5));
        tick();
        settle_check("t2_s2");
        chk("t2_bbl2", 64'(sbif.bbl), 64'(1));
        tick();
        settle_check("t2_s3");
        chk("t2_bbl3", 64'(sbif.bbl), 64'(0));
        chk("t2_tar3", 64'(sbif.tar_addr), 64'(0));
        chk("t2_stall", 64'(sbif.stall_cnt), 64'(2));
        drain();

        // 3. Issue r7 lat 2 while port 1 reads r7 in the same cycle.
        set_iss(1, 7, 2);
        set_rd(1, 1, 7);
        settle_check("t3");
        chk("t3_bbl", 64'(sbif.bbl), 64'(0));
        tick();
        clear_inputs();
        drain();

        // 4. r3 at count 1, r4 at count 2; port0 reads r4, port1 reads r3.
        set_iss(1, 3, 2);
        tick();
        set_iss(1, 4, 2);
        tick();
        clear_inputs();
        set_rd(0, 1, 4);
        set_rd(1, 1, 3);
        settle_check("t4_a");
        chk("t4_tar_a", 64'(sbif.tar_addr), 64'(4));
        tick();
        settle_check("t4_b");
        chk("t4_bbl_b", 64'(sbif.bbl), 64'(1));
        chk("t4_tar_b", 64'(sbif.tar_addr), 64'(4));
        chk("t4_p3_b", 64'(sbif.pending[3]), 64'(0));
        drain();

        // 5. WAW: r9 lat 5 followed by r9 lat 1.
        set_iss(1, 9, 5);
        tick();
        set_iss(1, 9, 1);
        tick();
        clear_inputs();
        settle_check("t5_a");
        chk("t5_p9_a", 64'(sbif.pending[9]), 64'(1));
        tick();
        settle_check("t5_b");
        chk("t5_p9_b", 64'(sbif.pending[9]), 64'(0));
        drain();

        // 6. Issue to r0, then an issue presented during a bubble.
        set_iss(1, 0, 7);
        tick();
        clear_inputs();
        settle_check("t6_r0");
        chk("t6_pend_r0", 64'(sbif.pending), 64'(0));
        set_iss(1, 10, 3);
        tick();
        set_iss(1, 11, 4);
        set_rd(0, 1, 10);
        settle_check("t6_stall");
        chk("t6_bbl", 64'(sbif.bbl), 64'(1));
        tick();
        sbif.iss_valid = 1'b0;
        settle_check("t6_after");
        chk("t6_p11", 64'(sbif.pending[11]), 64'(0));

        // 7. Reset asserted mid-cycle while the bubble is up.
        chk("t7_bbl_pre", 64'(sbif.bbl), 64'(1));
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t7_bbl", 64'(sbif.bbl), 64'(0));
        chk("t7_pend", 64'(sbif.pending), 64'(0));
        check_all("t7");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();

        // Random traffic against the model, including out-of-range addresses.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NRD; i++) begin
                set_rd(i, int'($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(NR, 31))
                                                   : int'($urandom_range(0, 7)));
            end
            set_iss(int'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(NR, 31))
                                                : int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
            settle_check("rnd");
            tick();
        end
        clear_inputs();
        settle_check("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
